// File: rtl/bias_addr_seq_if.sv
// Bias-RAM read-request bundle issued by bias_addr_seq.
//   ram_addr   bias RAM read address
//   ram_rd_en  one-cycle read strobe
//   grp_idx    output-layer group index of the current read
//   lane_mask  valid lanes of the current group
// The master modport drives the bundle (the sequencer). The slave modport
// observes it (bias RAM / NPE side).
interface bias_addr_seq_if #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned LAYER_WIDTH = 10,
    parameter int unsigned CH_PAR      = 4
);
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic                   ram_rd_en;
    logic [LAYER_WIDTH-1:0] grp_idx;
    logic [CH_PAR-1:0]      lane_mask;

    modport master (
        output ram_addr,
        output ram_rd_en,
        output grp_idx,
        output lane_mask
    );

    modport slave (
        input ram_addr,
        input ram_rd_en,
        input grp_idx,
        input lane_mask
    );
endinterface

// File: rtl/bias_addr_seq.sv
// Bias-RAM read sequencer for the NPU core.
// A start pulse latches the output-tensor geometry. The walk then visits X
// (fastest), then output-layer group, then Y, and advances one step for each
// NPE result beat. One bias read is issued at the start of every X-run. A
// lane mask accompanies each read and marks the valid lanes of a partial last
// group.
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_calc_en         start pulse: latches config and (re)starts the walk
//   i_out_x_length    beats per X-run
//   i_out_y_length    number of rows
//   i_output_layers   number of output layers L
//   i_base_addr       bias RAM address of group 0
//   i_npe_dat_vld     one NPE result beat consumed
//   ram_if (master)   ram_addr / ram_rd_en / grp_idx / lane_mask
//   o_busy            walk in progress
//   o_done            one-cycle pulse after the final beat
//   o_cfg_err         sticky: zero X, Y or L at start
//   o_ovf_err         sticky: beat received while idle
module bias_addr_seq #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DIM_WIDTH   = 12,
    parameter int unsigned LAYER_WIDTH = 10,
    parameter int unsigned CH_PAR      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_calc_en,
    input  logic [DIM_WIDTH-1:0]   i_out_x_length,
    input  logic [DIM_WIDTH-1:0]   i_out_y_length,
    input  logic [LAYER_WIDTH-1:0] i_output_layers,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic                   i_npe_dat_vld,
    bias_addr_seq_if.master        ram_if,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cfg_err,
    output logic                   o_ovf_err
);

    localparam int unsigned ChShift = $clog2(CH_PAR);
    // Group counters are one bit wider so that L+CH_PAR-1 cannot overflow.
    localparam int unsigned GW = LAYER_WIDTH + 1;
    localparam int unsigned MW = GW + ChShift + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [DIM_WIDTH-1:0]   x_len_q, x_len_d;
    logic [DIM_WIDTH-1:0]   y_len_q, y_len_d;
    logic [LAYER_WIDTH-1:0] l_len_q, l_len_d;
    logic [GW-1:0]          g_len_q, g_len_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [DIM_WIDTH-1:0]   x_cnt_q, x_cnt_d;
    logic [DIM_WIDTH-1:0]   y_cnt_q, y_cnt_d;
    logic [GW-1:0]          g_cnt_q, g_cnt_d;

    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic                   rd_en_q, rd_en_d;
    logic [LAYER_WIDTH-1:0] grp_idx_q, grp_idx_d;
    logic [CH_PAR-1:0]      lane_mask_q, lane_mask_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   ovf_err_q, ovf_err_d;

    logic cfg_zero, beat, run_end, last_grp, last_row, final_beat;

    // Lane i is valid when its layer index grp*CH_PAR+i is below L.
    function automatic logic [CH_PAR-1:0] lane_mask_f(input logic [GW-1:0] grp,
                                                      input logic [LAYER_WIDTH-1:0] layers);
        logic [MW-1:0] first;
        lane_mask_f = '0;
        first = MW'(grp) << ChShift;
        for (int i = 0; i < CH_PAR; i++) begin
            lane_mask_f[i] = (first + MW'(i)) < MW'(layers);
        end
    endfunction

    assign cfg_zero   = (i_out_x_length == '0) || (i_out_y_length == '0) ||
                        (i_output_layers == '0);
    // Start has priority: a beat coincident with i_calc_en is discarded.
    assign beat       = (state_q == StRun) && i_npe_dat_vld && !i_calc_en;
    assign run_end    = beat && (x_cnt_q == x_len_q - DIM_WIDTH'(1));
    assign last_grp   = (g_cnt_q == g_len_q - GW'(1));
    assign last_row   = (y_cnt_q == y_len_q - DIM_WIDTH'(1));
    assign final_beat = run_end && last_grp && last_row;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_calc_en) begin
            state_d = cfg_zero ? StIdle : StRun;
        end else if (final_beat) begin
            state_d = StIdle;
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        x_len_d     = x_len_q;
        y_len_d     = y_len_q;
        l_len_d     = l_len_q;
        g_len_d     = g_len_q;
        base_d      = base_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        g_cnt_d     = g_cnt_q;
        ram_addr_d  = ram_addr_q;
        rd_en_d     = 1'b0;
        grp_idx_d   = grp_idx_q;
        lane_mask_d = lane_mask_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        ovf_err_d   = ovf_err_q;

        if (i_calc_en) begin
            x_len_d   = i_out_x_length;
            y_len_d   = i_out_y_length;
            l_len_d   = i_output_layers;
            g_len_d   = (GW'(i_output_layers) + GW'(CH_PAR - 1)) >> ChShift;
            base_d    = i_base_addr;
            x_cnt_d   = '0;
            y_cnt_d   = '0;
            g_cnt_d   = '0;
            ovf_err_d = 1'b0;
            cfg_err_d = cfg_zero;
            done_d    = cfg_zero;
            if (!cfg_zero) begin
                rd_en_d     = 1'b1;
                ram_addr_d  = i_base_addr;
                grp_idx_d   = '0;
                lane_mask_d = lane_mask_f('0, i_output_layers);
            end
        end else if (state_q == StIdle && i_npe_dat_vld) begin
            ovf_err_d = 1'b1;
        end else if (beat) begin
            if (!run_end) begin
                x_cnt_d = x_cnt_q + DIM_WIDTH'(1);
            end else begin
                x_cnt_d = '0;
                if (!last_grp) begin
                    g_cnt_d     = g_cnt_q + GW'(1);
                    rd_en_d     = 1'b1;
                    ram_addr_d  = base_q + ADDR_WIDTH'(g_cnt_q + GW'(1));
                    grp_idx_d   = LAYER_WIDTH'(g_cnt_q + GW'(1));
                    lane_mask_d = lane_mask_f(g_cnt_q + GW'(1), l_len_q);
                end else if (!last_row) begin
                    g_cnt_d     = '0;
                    y_cnt_d     = y_cnt_q + DIM_WIDTH'(1);
                    rd_en_d     = 1'b1;
                    ram_addr_d  = base_q;
                    grp_idx_d   = '0;
                    lane_mask_d = lane_mask_f('0, l_len_q);
                end else begin
                    g_cnt_d = '0;
                    y_cnt_d = '0;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_len_q     <= '0;
            y_len_q     <= '0;
            l_len_q     <= '0;
            g_len_q     <= '0;
            base_q      <= '0;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            g_cnt_q     <= '0;
            ram_addr_q  <= '0;
            rd_en_q     <= 1'b0;
            grp_idx_q   <= '0;
            lane_mask_q <= '0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            x_len_q     <= x_len_d;
            y_len_q     <= y_len_d;
            l_len_q     <= l_len_d;
            g_len_q     <= g_len_d;
            base_q      <= base_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            g_cnt_q     <= g_cnt_d;
            ram_addr_q  <= ram_addr_d;
            rd_en_q     <= rd_en_d;
            grp_idx_q   <= grp_idx_d;
            lane_mask_q <= lane_mask_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign ram_if.ram_addr  = ram_addr_q;
    assign ram_if.ram_rd_en = rd_en_q;
    assign ram_if.grp_idx   = grp_idx_q;
    assign ram_if.lane_mask = lane_mask_q;
    assign o_busy           = (state_q == StRun);
    assign o_done           = done_q;
    assign o_cfg_err        = cfg_err_q;
    assign o_ovf_err        = ovf_err_q;

endmodule

// File: tb/tb_bias_addr_seq.sv
// Testbench for bias_addr_seq: directed scenarios plus randomized walks,
// checked every cycle against a beat-count reference model.
module tb_bias_addr_seq;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 12;
    localparam int unsigned LW = 10;
    localparam int unsigned CP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          calc_en = 1'b0;
    logic [DW-1:0] x_len = '0;
    logic [DW-1:0] y_len = '0;
    logic [LW-1:0] layers = '0;
    logic [AW-1:0] base = '0;
    logic          npe_vld = 1'b0;
    logic          busy, done, cfg_err, ovf_err;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: a walk is a flat sequence of X*G*Y beats; a read
    // follows every beat count that is a multiple of X, except the last.
    bit          m_active;
    int          m_n, m_x, m_y, m_l, m_g, m_base;
    logic        e_rd, e_done, e_busy, e_cfg, e_ovf;
    logic [31:0] e_addr, e_grp, e_mask;

    bias_addr_seq_if #(.ADDR_WIDTH(AW), .LAYER_WIDTH(LW), .CH_PAR(CP)) ram_if ();

    bias_addr_seq #(
        .ADDR_WIDTH (AW),
        .DIM_WIDTH  (DW),
        .LAYER_WIDTH(LW),
        .CH_PAR     (CP)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_calc_en      (calc_en),
        .i_out_x_length (x_len),
        .i_out_y_length (y_len),
        .i_output_layers(layers),
        .i_base_addr    (base),
        .i_npe_dat_vld  (npe_vld),
        .ram_if         (ram_if),
        .o_busy         (busy),
        .o_done         (done),
        .o_cfg_err      (cfg_err),
        .o_ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_n = 0;
        e_rd = 0; e_done = 0; e_busy = 0; e_cfg = 0; e_ovf = 0;
        e_addr = 0; e_grp = 0; e_mask = 0;
    endtask

    task automatic model_read(input int g);
        e_rd   = 1;
        e_addr = (m_base + g) % (1 << AW);
        e_grp  = g;
        e_mask = 0;
        for (int i = 0; i < CP; i++) e_mask[i] = ((g * CP + i) < m_l);
    endtask

    task automatic model_step(input logic calc, input logic vld);
        e_rd = 0; e_done = 0;
        if (calc) begin
            m_x = x_len; m_y = y_len; m_l = layers; m_base = base;
            m_g = (m_l + CP - 1) / CP;
            m_n = 0; e_ovf = 0;
            if (m_x == 0 || m_y == 0 || m_l == 0) begin
                e_cfg = 1; e_done = 1; m_active = 0;
            end else begin
                e_cfg = 0; m_active = 1; model_read(0);
            end
        end else if (vld) begin
            if (!m_active) begin
                e_ovf = 1;
            end else begin
                m_n++;
                if (m_n == m_x * m_g * m_y) begin
                    e_done = 1; m_active = 0;
                end else if (m_n % m_x == 0) begin
                    model_read((m_n / m_x) % m_g);
                end
            end
        end
        e_busy = m_active;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_en"}, 32'(ram_if.ram_rd_en), 32'(e_rd));
        check({tag, ".addr"}, 32'(ram_if.ram_addr), e_addr);
        check({tag, ".grp"}, 32'(ram_if.grp_idx), e_grp);
        check({tag, ".mask"}, 32'(ram_if.lane_mask), e_mask);
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".cfg_err"}, 32'(cfg_err), 32'(e_cfg));
        check({tag, ".ovf_err"}, 32'(ovf_err), 32'(e_ovf));
    endtask

    // Apply inputs for one clock, advance the model, sample 1 time unit later.
    task automatic step(input string tag, input logic calc, input logic vld);
        calc_en = calc; npe_vld = vld;
        @(posedge clk);
        model_step(calc, vld);
        #1;
        calc_en = 0; npe_vld = 0;
        check_all(tag);
    endtask

    task automatic set_cfg(input int x, input int y, input int l, input int b);
        x_len = DW'(x); y_len = DW'(y); layers = LW'(l); base = AW'(b);
    endtask

    task automatic beats(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 1);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1;
        @(posedge clk); #1;
        check_all("post_reset");

        // Single row, two full groups.
        set_cfg(4, 1, 8, 'h10);
        step("t1_start", 1, 0);
        check("t1_first_addr", 32'(ram_if.ram_addr), 32'h10);
        check("t1_first_mask", 32'(ram_if.lane_mask), 32'hf);
        beats("t1_run0", 4);
        check("t1_second_addr", 32'(ram_if.ram_addr), 32'h11);
        beats("t1_run1", 4);
        check("t1_done", 32'(done), 32'h1);
        step("t1_idle", 0, 0);

        // Partial last group, two rows; idle gaps between beats.
        set_cfg(2, 2, 6, 0);
        step("t2_start", 1, 0);
        for (int i = 0; i < 8; i++) begin
            step("t2_beat", 0, 1);
            if (i == 1) check("t2_part_mask", 32'(ram_if.lane_mask), 32'h3);
            step("t2_gap", 0, 0);
        end

        // Address wrap-around.
        set_cfg(1, 1, 8, 'h1ff);
        step("t3_start", 1, 0);
        step("t3_beat", 0, 1);
        check("t3_wrap_addr", 32'(ram_if.ram_addr), 32'h0);
        beats("t3_end", 1);

        // Zero geometry at start.
        set_cfg(3, 2, 0, 5);
        step("t4_l0", 1, 0);
        check("t4_cfg_err", 32'(cfg_err), 32'h1);
        step("t4_idle", 0, 0);
        set_cfg(0, 2, 4, 5);
        step("t4_x0", 1, 0);
        set_cfg(3, 0, 4, 5);
        step("t4_y0", 1, 0);

        // Beat while idle.
        step("t5_ovf", 0, 1);
        step("t5_hold", 0, 0);

        // Restart mid-walk with a coincident beat.
        set_cfg(2, 2, 6, 0);
        step("t6_start", 1, 0);
        beats("t6_part", 3);
        set_cfg(3, 1, 4, 'h55);
        step("t6_restart", 1, 1);
        check("t6_new_addr", 32'(ram_if.ram_addr), 32'h55);
        beats("t6_new", 3);

        // Asynchronous reset in the middle of a walk.
        set_cfg(3, 2, 9, 'h20);
        step("t7_start", 1, 0);
        beats("t7_part", 4);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all("t7_async_rst");
        #2 rst_n = 1;
        step("t7_after", 0, 0);
        step("t7_ovf", 0, 1);

        // Randomized walks with random gaps, idle beats and restarts.
        for (int r = 0; r < 16; r++) begin
            int cyc;
            set_cfg($urandom_range(4, 1), $urandom_range(3, 1),
                    ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(20, 1),
                    $urandom_range(511, 0));
            step("rnd_start", 1, 1'($urandom_range(1, 0)));
            cyc = 0;
            while (m_active && cyc < 400) begin
                if ($urandom_range(49, 0) == 0) begin
                    set_cfg($urandom_range(4, 1), $urandom_range(3, 1),
                            $urandom_range(20, 1), $urandom_range(511, 0));
                    step("rnd_restart", 1, 1'($urandom_range(1, 0)));
                end else begin
                    step("rnd_step", 0, 1'($urandom_range(9, 0) < 7));
                end
                cyc++;
            end
            check("rnd_walk_bound", 32'(m_active), 32'h0);
            step("rnd_idle", 0, 1'($urandom_range(3, 0) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
